// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, NOP word, PC step and opcode field layout.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_PEND = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int unsigned PC_INCR  = 4;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register for a fetched word that decode could not take yet.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              clear_i,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc_q;

    // Clear beats load beats unload; data is only captured on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc_q    <= {ADDR_W{1'b0}};
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register: req/ack fetch FSM, decode stall and branch redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter logic [31:0]       NOP_INSTR = NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [5:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4
);

    localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, target_q, target_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ifpc_q, ifpc_d, ifpc4_q, ifpc4_d;

    logic              slot_free_s, consumed_s;
    logic              skid_load_s, skid_unload_s, skid_clear_s, skid_valid_s;
    logic [31:0]       skid_instr_s;
    logic [ADDR_W-1:0] skid_pc_s;

    assign consumed_s  = valid_q && !stall;
    assign slot_free_s = !valid_q || !stall;

    fetch_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load_s),
        .unload_i (skid_unload_s),
        .clear_i  (skid_clear_s),
        .instr_i  (imem_rdata),
        .pc_i     (pc_q),
        .valid_o  (skid_valid_s),
        .instr_o  (skid_instr_s),
        .pc_o     (skid_pc_s)
    );

    // Next-state: fetch FSM, IF/ID load/consume, then redirect overriding everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        ifpc_d        = ifpc_q;
        ifpc4_d       = ifpc4_q;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        skid_clear_s  = 1'b0;

        if (consumed_s) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    if (slot_free_s) begin
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        ifpc_d  = pc_q;
                        ifpc4_d = pc_q + INCR;
                    end else begin
                        skid_load_s = 1'b1;
                        state_d     = S_PEND;
                    end
                    pc_d = pc_q + INCR;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_PEND: begin
                // An empty skid here can only follow a flush; just resume fetching.
                if (!skid_valid_s) begin
                    state_d = S_REQ;
                end else if (slot_free_s) begin
                    valid_d       = 1'b1;
                    instr_d       = skid_instr_s;
                    ifpc_d        = skid_pc_s;
                    ifpc4_d       = skid_pc_s + INCR;
                    skid_unload_s = 1'b1;
                    state_d       = S_REQ;
                end else begin
                    state_d = S_PEND;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    pc_d    = target_q;
                    state_d = S_REQ;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            valid_d       = 1'b0;
            instr_d       = NOP_INSTR;
            skid_load_s   = 1'b0;
            skid_unload_s = 1'b0;
            skid_clear_s  = 1'b1;
            case (state_q)
                S_REQ, S_DROP: begin
                    // The outstanding fetch must still complete before the target can go out.
                    if (imem_ack) begin
                        pc_d    = redirect_pc;
                        state_d = S_REQ;
                    end else begin
                        pc_d     = pc_q;
                        target_d = redirect_pc;
                        state_d  = S_DROP;
                    end
                end
                default: begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end
            endcase
        end else begin
            skid_clear_s = 1'b0;
        end

        req_d  = (state_d == S_REQ) || (state_d == S_DROP);
        addr_d = pc_d;
    end

    // State, PC and IF/ID registers; request outputs registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            ifpc_q   <= RESET_PC;
            ifpc4_q  <= RESET_PC + INCR;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            ifpc4_q  <= ifpc4_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_opcode   = opcode_of(instr_q);
    assign if_pc       = ifpc_q;
    assign if_pc_plus4 = ifpc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait fetch, wait states, stall/skid, redirects, reset and PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_opcode;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        ack_en;

    int total_cnt  = 0;
    int passed_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h8C01_0004;
            32'h0000_0004: mem_word = 32'h2042_0001;
            default:       mem_word = {16'h1400, a[15:0]};
        endcase
    endfunction

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem_word(imem_addr);

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ack_en = 1'b1;
        tick();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_pc",    if_pc, 32'h0);
        chk("rst_pc4",   if_pc_plus4, 32'h4);
        rst = 1'b0;
        tick();
        chk("first_req",   {31'd0, imem_req}, 32'd1);
        chk("first_addr",  imem_addr, 32'h0);
        chk("first_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("f0_valid",  {31'd0, if_valid}, 32'd1);
        chk("f0_opcode", {26'd0, if_opcode}, 32'h23);
        chk("f0_pc",     if_pc, 32'h0);
        chk("f0_pc4",    if_pc_plus4, 32'h4);
        chk("f0_addr",   imem_addr, 32'h4);
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req",   {31'd0, imem_req}, 32'd1);
            chk("wait_addr",  imem_addr, 32'h4);
            chk("wait_valid", {31'd0, if_valid}, 32'd0);
        end
        ack_en = 1'b1;
        tick();
        chk("f4_valid",  {31'd0, if_valid}, 32'd1);
        chk("f4_opcode", {26'd0, if_opcode}, 32'h08);
        chk("f4_pc",     if_pc, 32'h4);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req",   {31'd0, imem_req}, 32'd0);
            chk("stall_pc",    if_pc, 32'h4);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("skid_pc",    if_pc, 32'h8);
        chk("skid_instr", if_instr, 32'h1400_0008);
        chk("skid_req",   {31'd0, imem_req}, 32'd1);
        chk("skid_addr",  imem_addr, 32'hC);
        tick();
        chk("fc_pc",   if_pc, 32'hC);
        chk("fc_addr", imem_addr, 32'h10);
        ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("drop_valid", {31'd0, if_valid}, 32'd0);
        chk("drop_instr", if_instr, 32'h0);
        chk("drop_req",   {31'd0, imem_req}, 32'd1);
        chk("drop_addr",  imem_addr, 32'h10);
        redirect = 1'b0;
        tick();
        chk("drop2_addr", imem_addr, 32'h10);
        ack_en = 1'b1;
        tick();
        chk("drop_discard", {31'd0, if_valid}, 32'd0);
        chk("tgt_addr",     imem_addr, 32'h40);
        tick();
        chk("tgt_valid", {31'd0, if_valid}, 32'd1);
        chk("tgt_pc",    if_pc, 32'h40);
        chk("tgt_instr", if_instr, 32'h1400_0040);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        chk("flush_valid",  {31'd0, if_valid}, 32'd0);
        chk("flush_instr",  if_instr, 32'h0);
        chk("flush_opcode", {26'd0, if_opcode}, 32'h0);
        chk("flush_addr",   imem_addr, 32'h80);
        stall = 1'b0; redirect = 1'b0;
        tick();
        chk("t80_valid", {31'd0, if_valid}, 32'd1);
        chk("t80_pc",    if_pc, 32'h80);
        chk("t80_pc4",   if_pc_plus4, 32'h84);
        ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        chk("d2_addr",  imem_addr, 32'h84);
        chk("d2_valid", {31'd0, if_valid}, 32'd0);
        redirect = 1'b0; rst = 1'b1;
        tick();
        chk("mrst_req",   {31'd0, imem_req}, 32'd0);
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_addr",  imem_addr, 32'h0);
        rst = 1'b0; ack_en = 1'b1;
        tick();
        chk("rs_req",  {31'd0, imem_req}, 32'd1);
        chk("rs_addr", imem_addr, 32'h0);
        tick();
        chk("rs_instr", if_instr, 32'h8C01_0004);
        chk("rs_pc",    if_pc, 32'h0);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        tick();
        chk("wrap_pc",    if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4",   if_pc_plus4, 32'h0);
        chk("wrap_instr", if_instr, 32'h1400_FFFC);
        chk("wrap_next",  imem_addr, 32'h0);
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
